// File: rtl/sw_batch_sequencer.sv
// sw_batch_sequencer: on-chip batch driver for the Smith-Waterman wrapper.
// It optionally loads the target once, then runs every parameter set in a
// small table. Each score is reported with its latency, and the batch best
// is tracked. A per-wait watchdog abandons the batch if the core hangs.
module sw_batch_sequencer #(
    parameter int NUM_RUNS = 2,
    parameter int SCORE_W  = 4,
    parameter int RESULT_W = 16,
    parameter int TIMEOUT  = 50_000_000,
    localparam int IDX_W   = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_go,
    input  logic                  i_skip_set_t,
    input  logic                  i_param_we,
    input  logic [IDX_W-1:0]      i_param_addr,
    input  logic [4*SCORE_W-1:0]  i_param_data,
    output logic                  o_set_t,
    output logic                  o_start_cal,
    output logic [SCORE_W-1:0]    o_match,
    output logic [SCORE_W-1:0]    o_mismatch,
    output logic [SCORE_W-1:0]    o_minusAlpha,
    output logic [SCORE_W-1:0]    o_minusBeta,
    input  logic                  i_busy,
    input  logic                  i_valid,
    input  logic [RESULT_W-1:0]   i_result,
    output logic                  o_res_valid,
    output logic [IDX_W-1:0]      o_res_idx,
    output logic [RESULT_W-1:0]   o_res_data,
    output logic [31:0]           o_run_cycles,
    output logic [RESULT_W-1:0]   o_best,
    output logic [IDX_W-1:0]      o_best_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam int PAR_W = 4 * SCORE_W;
    // The watchdog only has to count up to TIMEOUT-1 before it fires.
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);

    typedef enum logic [3:0] {
        IDLE, SET_T, SET_GUARD, WAIT_SETT, LOAD,
        START, WAIT_VALID, WAIT_IDLE, NEXT, DONE
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PAR_W-1:0]      par_q, par_d;
    logic [31:0]           run_cnt_q, run_cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  res_valid_q, res_valid_d;
    logic [IDX_W-1:0]      res_idx_q, res_idx_d;
    logic [RESULT_W-1:0]   res_data_q, res_data_d;
    logic [31:0]           run_cycles_q, run_cycles_d;
    logic [RESULT_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]      best_idx_q, best_idx_d;
    logic                  timeout_q, timeout_d;
    logic                  wd_expired;

    logic [PAR_W-1:0]      param_tbl_q [NUM_RUNS];

    // Parameter table: written by the board only while the sequencer is idle.
    always_ff @(posedge clk) begin
        // NOTE: the table is plain storage with no reset, so it survives a batch abort and maps onto RAM.
        // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
        if (i_param_we && (state_q == IDLE) && (int'(i_param_addr) < NUM_RUNS)) begin
            param_tbl_q[i_param_addr] <= i_param_data;
        end
    end

    // The current wait state has spent TIMEOUT cycles without progress.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    // Next-state logic plus run bookkeeping, result capture and best tracking.
    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can leave a latch behind.
        state_d      = state_q;
        idx_d        = idx_q;
        par_d        = par_q;
        run_cnt_d    = run_cnt_q;
        wd_d         = wd_q + WD_W'(1);
        res_valid_d  = 1'b0;
        res_idx_d    = res_idx_q;
        res_data_d   = res_data_q;
        run_cycles_d = run_cycles_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (i_go) begin
                    best_d     = '0;
                    best_idx_d = '0;
                    timeout_d  = 1'b0;
                    idx_d      = '0;
                    state_d    = i_skip_set_t ? LOAD : SET_T;
                end
            end
            SET_T:     state_d = SET_GUARD;
            // The core may not raise busy immediately, so one cycle is spent
            // here before busy is trusted.
            SET_GUARD: state_d = WAIT_SETT;
            WAIT_SETT: begin
                if (!i_busy) begin
                    state_d = LOAD;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOAD: state_d = START;
            START: begin
                run_cnt_d = 32'd1;
                state_d   = WAIT_VALID;
            end
            WAIT_VALID: begin
                run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
                if (i_valid) begin
                    res_valid_d  = 1'b1;
                    res_idx_d    = idx_q;
                    res_data_d   = i_result;
                    run_cycles_d = run_cnt_q;
                    // The first run always seeds the best; ties keep the earlier run.
                    if ((idx_q == '0) || (i_result > best_q)) begin
                        best_d     = i_result;
                        best_idx_d = idx_q;
                    end
                    state_d = WAIT_IDLE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!i_busy) begin
                    state_d = NEXT;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Each wait state gets the full watchdog window starting from its first cycle.
        if ((state_d != state_q) &&
            ((state_d == WAIT_SETT) || (state_d == WAIT_VALID) || (state_d == WAIT_IDLE))) begin
            wd_d = '0;
        end

        // Parameters are latched on the way into LOAD so they are already valid during LOAD.
        if (state_d == LOAD) begin
            par_d = param_tbl_q[idx_d];
        end
    end

    // State and datapath registers; reset aborts any batch without pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            par_q        <= '0;
            run_cnt_q    <= '0;
            wd_q         <= '0;
            res_valid_q  <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            run_cycles_q <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            par_q        <= par_d;
            run_cnt_q    <= run_cnt_d;
            wd_q         <= wd_d;
            res_valid_q  <= res_valid_d;
            res_idx_q    <= res_idx_d;
            res_data_q   <= res_data_d;
            run_cycles_q <= run_cycles_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_set_t     = (state_q == SET_T);
    assign o_start_cal = (state_q == START);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign {o_match, o_mismatch, o_minusAlpha, o_minusBeta} = par_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_idx    = res_idx_q;
    assign o_res_data   = res_data_q;
    assign o_run_cycles = run_cycles_q;
    assign o_best       = best_q;
    assign o_best_idx   = best_idx_q;
    assign o_timeout    = timeout_q;

endmodule
